// File: rtl/dds_phase_accumulator.sv
// NCO phase accumulator with FTW scheduling and a 3-stage phase/triangle/square pipe.
// Define DDS_DITHER_EN to add LFSR dither ahead of phase truncation.
module dds_phase_accumulator #(
  parameter int PHASE_BITS       = 16,
  parameter int AMP_BITS         = 12,
  parameter int PHASE_CONTINUOUS = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [31:0]           dds_freq,
  input  logic                  frequency_update,
  input  logic                  sweep_start,
  output logic [31:0]           phase_acc,
  output logic [PHASE_BITS-1:0] phase_out,
  output logic [AMP_BITS-1:0]   tri_out,
  output logic                  sq_out,
  output logic                  wrap,
  output logic                  out_valid,
  output logic [31:0]           ftw_active
);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  localparam logic [AMP_BITS-1:0] HALF =
    {1'b1, {(AMP_BITS-1){1'b0}}};
  localparam logic [AMP_BITS-1:0] HALF_M1 = ~HALF;

  state_t state;
  state_t state_n;
  logic   fill;
  logic   fill_n;

  logic [31:0] pending;
  logic        pend_flag;
  logic [32:0] sum;
  logic        run;
  logic        apply;

  logic [PHASE_BITS-1:0] trunc;
  logic [PHASE_BITS-1:0] p2;
  logic [AMP_BITS:0]     t;
  logic [AMP_BITS-1:0]   lo;
  logic [AMP_BITS-1:0]   tri_d;

  // fill marks the second PRIME cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      fill      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      fill      <= fill_n;
      out_valid <= (state_n == RUN);
    end
  end

  always_comb begin
    state_n = state;
    fill_n  = 1'b0;
    if (sweep_start) begin
      state_n = PRIME;
    end else if (!enable) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE:  state_n = PRIME;
        PRIME: begin
          fill_n = ~fill;
          if (fill) state_n = RUN;
        end
        RUN:     state_n = RUN;
        default: state_n = IDLE;
      endcase
    end
  end

  assign run = enable && (state != IDLE);
  assign sum = {1'b0, phase_acc} + {1'b0, ftw_active};

  // continuous mode waits for the carry so the new FTW starts at phase 0
  assign apply = pend_flag && run &&
                 ((PHASE_CONTINUOUS == 0) || sum[32]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_acc  <= '0;
      wrap       <= 1'b0;
      ftw_active <= '0;
      pending    <= '0;
      pend_flag  <= 1'b0;
    end else if (sweep_start) begin
      phase_acc  <= '0;
      wrap       <= 1'b0;
      ftw_active <= dds_freq;
      pending    <= '0;
      pend_flag  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (run) begin
        phase_acc <= sum[31:0];
        wrap      <= sum[32];
      end
      if (apply) begin
        ftw_active <= pending;
      end
      if (frequency_update) begin
        pending   <= dds_freq;
        pend_flag <= 1'b1;
      end else if (apply) begin
        pend_flag <= 1'b0;
      end
    end
  end

`ifdef DDS_DITHER_EN
  localparam logic [31:0] DMASK =
    (32'h1 << (32 - PHASE_BITS)) - 32'h1;
  localparam logic [15:0] SEED = 16'hACE1;

  logic [15:0] lfsr;
  logic        fb;
  logic [31:0] phase_d;

  assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= SEED;
    end else if (sweep_start) begin
      lfsr <= SEED;
    end else if (state != IDLE) begin
      lfsr <= {lfsr[14:0], fb};
    end
  end

  // carry out of the discarded bits rounds into the kept phase
  assign phase_d = phase_acc + ({16'h0, lfsr} & DMASK);
  assign trunc   = phase_d[31 -: PHASE_BITS];
`else
  assign trunc = phase_acc[31 -: PHASE_BITS];
`endif

  assign t     = p2[PHASE_BITS-1 -: AMP_BITS+1];
  assign lo    = t[AMP_BITS-1:0];
  assign tri_d = t[AMP_BITS] ? (HALF_M1 - lo) : (lo - HALF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p2        <= '0;
      phase_out <= '0;
      tri_out   <= '0;
      sq_out    <= 1'b0;
    end else begin
      p2        <= trunc;
      phase_out <= p2;
      tri_out   <= tri_d;
      sq_out    <= p2[PHASE_BITS-1];
    end
  end

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// Bench for dds_phase_accumulator: continuous and immediate FTW instances
// driven in parallel and checked against a behavioural model every cycle.
module tb_dds_phase_accumulator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        frequency_update;
  logic        sweep_start;
  logic [31:0] dds_freq;

  logic [31:0] acc_c, ftw_c, acc_i, ftw_i;
  logic [15:0] ph_c, ph_i;
  logic [11:0] tri_c, tri_i;
  logic        sq_c, sq_i, wrap_c, wrap_i, val_c, val_i;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dds_phase_accumulator #(
    .PHASE_BITS(16), .AMP_BITS(12), .PHASE_CONTINUOUS(1)
  ) dut_c (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .dds_freq(dds_freq), .frequency_update(frequency_update),
    .sweep_start(sweep_start), .phase_acc(acc_c),
    .phase_out(ph_c), .tri_out(tri_c), .sq_out(sq_c),
    .wrap(wrap_c), .out_valid(val_c), .ftw_active(ftw_c)
  );

  dds_phase_accumulator #(
    .PHASE_BITS(16), .AMP_BITS(12), .PHASE_CONTINUOUS(0)
  ) dut_i (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .dds_freq(dds_freq), .frequency_update(frequency_update),
    .sweep_start(sweep_start), .phase_acc(acc_i),
    .phase_out(ph_i), .tri_out(tri_i), .sq_out(sq_i),
    .wrap(wrap_i), .out_valid(val_i), .ftw_active(ftw_i)
  );

  // model: index 0 = continuous, 1 = immediate
  logic [31:0] m_acc[2], m_ftw[2], m_pend[2], m_h1[2], m_h2[2];
  bit          m_pflag[2], m_live[2], m_wrap[2];
  int          m_streak[2];

  task automatic chk(string tag, int i, logic [31:0] got,
                     logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] observed=%h expected=%h",
             tag, i, got, exp);
    end
  endtask

  function automatic logic [11:0] tri_of(logic [31:0] ph);
    int t;
    int v;
    t = int'({19'd0, ph[31:19]});
    v = (t < 4096) ? t - 2048 : 2047 - (t - 4096);
    return v[11:0];
  endfunction

  task automatic mclear(int i);
    m_acc[i]    = '0;
    m_ftw[i]    = '0;
    m_pend[i]   = '0;
    m_h1[i]     = '0;
    m_h2[i]     = '0;
    m_pflag[i]  = 1'b0;
    m_live[i]   = 1'b0;
    m_wrap[i]   = 1'b0;
    m_streak[i] = 0;
  endtask

  task automatic mstep(int i);
    logic [63:0] s;
    if (!reset_n) begin
      mclear(i);
    end else begin
      m_h2[i]   = m_h1[i];
      m_h1[i]   = m_acc[i];
      m_wrap[i] = 1'b0;
      if (sweep_start) begin
        m_acc[i]    = '0;
        m_ftw[i]    = dds_freq;
        m_pend[i]   = '0;
        m_pflag[i]  = 1'b0;
        m_live[i]   = 1'b1;
        m_streak[i] = 0;
      end else if (!enable) begin
        m_live[i]   = 1'b0;
        m_streak[i] = 0;
      end else if (!m_live[i]) begin
        m_live[i]   = 1'b1;
        m_streak[i] = 0;
      end else begin
        s = {32'd0, m_acc[i]} + {32'd0, m_ftw[i]};
        m_acc[i]  = s[31:0];
        m_wrap[i] = (s >= 64'h1_0000_0000);
        if (m_pflag[i] && (i == 1 || m_wrap[i])) begin
          m_ftw[i]   = m_pend[i];
          m_pflag[i] = 1'b0;
        end
        if (m_streak[i] < 2) m_streak[i]++;
      end
      if (!sweep_start && frequency_update) begin
        m_pend[i]  = dds_freq;
        m_pflag[i] = 1'b1;
      end
    end
  endtask

  task automatic check_one(int i, logic [31:0] pa, logic [31:0] fa,
                           logic w, logic v, logic [15:0] po,
                           logic [11:0] tr, logic sq);
    bit ev;
    ev = m_live[i] && (m_streak[i] >= 2);
    chk("phase_acc", i, pa, m_acc[i]);
    chk("ftw_active", i, fa, m_ftw[i]);
    chk("wrap", i, 32'(w), 32'(m_wrap[i]));
    chk("out_valid", i, 32'(v), 32'(ev));
    if (ev) begin
      chk("phase_out", i, 32'(po), 32'(m_h2[i][31:16]));
      chk("tri_out", i, 32'(tr), 32'(tri_of(m_h2[i])));
      chk("sq_out", i, 32'(sq), 32'(m_h2[i][31]));
    end
  endtask

  task automatic check_zero(int i, logic [31:0] pa, logic [31:0] fa,
                            logic w, logic v, logic [15:0] po,
                            logic [11:0] tr, logic sq);
    chk("rst_acc", i, pa, 32'd0);
    chk("rst_ftw", i, fa, 32'd0);
    chk("rst_wrap", i, 32'(w), 32'd0);
    chk("rst_valid", i, 32'(v), 32'd0);
    chk("rst_phase", i, 32'(po), 32'd0);
    chk("rst_tri", i, 32'(tr), 32'd0);
    chk("rst_sq", i, 32'(sq), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    mstep(0);
    mstep(1);
    #1;
    check_one(0, acc_c, ftw_c, wrap_c, val_c, ph_c, tri_c, sq_c);
    check_one(1, acc_i, ftw_i, wrap_i, val_i, ph_i, tri_i, sq_i);
    @(negedge clk);
  endtask

  initial begin
    reset_n          = 1'b0;
    enable           = 1'b0;
    frequency_update = 1'b0;
    sweep_start      = 1'b0;
    dds_freq         = '0;
    mclear(0);
    mclear(1);

    @(negedge clk);
    check_zero(0, acc_c, ftw_c, wrap_c, val_c, ph_c, tri_c, sq_c);
    check_zero(1, acc_i, ftw_i, wrap_i, val_i, ph_i, tri_i, sq_i);
    tick();
    reset_n = 1'b1;
    tick();
    tick();

    // quarter-rate sweep
    dds_freq    = 32'h4000_0000;
    sweep_start = 1'b1;
    enable      = 1'b1;
    tick();
    chk("sweep_acc", 0, acc_c, 32'h0);
    chk("sweep_ftw", 0, ftw_c, 32'h4000_0000);
    sweep_start = 1'b0;
    tick();
    chk("prime_valid", 0, 32'(val_c), 32'd0);
    tick();
    chk("valid_rise", 0, 32'(val_c), 32'd1);
    chk("tri_a", 0, 32'(tri_c), 32'h800);
    tick();
    chk("tri_b", 0, 32'(tri_c), 32'h000);
    tick();
    chk("tri_c", 0, 32'(tri_c), 32'h7FF);
    chk("wrap_ret0", 0, 32'(wrap_c), 32'd1);
    tick();
    chk("tri_d", 0, 32'(tri_c), 32'hFFF);
    chk("acc_q1", 0, acc_c, 32'h4000_0000);

    // tuning change at phase 0x40000000
    frequency_update = 1'b1;
    dds_freq         = 32'h2000_0000;
    tick();
    frequency_update = 1'b0;
    chk("pc_hold", 0, ftw_c, 32'h4000_0000);
    tick();
    chk("imm_ftw", 1, ftw_i, 32'h2000_0000);
    chk("imm_acc", 1, acc_i, 32'hC000_0000);
    chk("pc_hold2", 0, ftw_c, 32'h4000_0000);
    tick();
    chk("pc_wrap_acc", 0, acc_c, 32'h0);
    chk("pc_new_ftw", 0, ftw_c, 32'h2000_0000);
    tick();
    chk("pc_acc1", 0, acc_c, 32'h2000_0000);
    tick();
    chk("pc_acc2", 0, acc_c, 32'h4000_0000);

    // sweep beats a simultaneous update and flushes pending
    frequency_update = 1'b1;
    dds_freq         = 32'h1111_1111;
    tick();
    sweep_start = 1'b1;
    dds_freq    = 32'h0800_0000;
    tick();
    chk("sw_acc", 0, acc_c, 32'h0);
    chk("sw_ftw_c", 0, ftw_c, 32'h0800_0000);
    chk("sw_ftw_i", 1, ftw_i, 32'h0800_0000);
    sweep_start      = 1'b0;
    frequency_update = 1'b0;
    dds_freq         = 32'hDEAD_BEEF;
    for (int k = 0; k < 70; k++) tick();
    chk("sw_keep_c", 0, ftw_c, 32'h0800_0000);
    chk("sw_keep_i", 1, ftw_i, 32'h0800_0000);

    // pause for 5 cycles
    enable = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("pause_valid", 0, 32'(val_c), 32'd0);
    enable = 1'b1;
    tick();
    tick();
    chk("reprime", 0, 32'(val_c), 32'd0);
    tick();
    chk("resume", 0, 32'(val_c), 32'd1);
    for (int k = 0; k < 4; k++) tick();

    // full-scale FTW
    dds_freq    = 32'hFFFF_FFFF;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    tick();
    chk("max_first", 0, 32'(wrap_c), 32'd0);
    chk("max_acc1", 0, acc_c, 32'hFFFF_FFFF);
    tick();
    chk("max_second", 0, 32'(wrap_c), 32'd1);
    chk("max_acc2", 0, acc_c, 32'hFFFF_FFFE);
    for (int k = 0; k < 4; k++) tick();

    // zero FTW, then an update captured while disabled
    dds_freq    = 32'h0;
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("zero_hold", 0, acc_c, 32'h0);
    enable           = 1'b0;
    frequency_update = 1'b1;
    dds_freq         = 32'h3000_0000;
    tick();
    frequency_update = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    enable = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    chk("dis_upd_i", 1, ftw_i, 32'h3000_0000);
    chk("dis_upd_c", 0, ftw_c, 32'h0);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      enable           = ($urandom_range(0, 9) != 0);
      sweep_start      = ($urandom_range(0, 29) == 0);
      frequency_update = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0)
        dds_freq = $urandom() >> $urandom_range(0, 8);
      else
        dds_freq = $urandom();
      tick();
    end

    // asynchronous reset mid-run with an update pending
    enable           = 1'b1;
    frequency_update = 1'b0;
    dds_freq         = 32'h4000_0000;
    sweep_start      = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    frequency_update = 1'b1;
    dds_freq         = 32'h1234_5678;
    tick();
    frequency_update = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    mclear(0);
    mclear(1);
    check_zero(0, acc_c, ftw_c, wrap_c, val_c, ph_c, tri_c, sq_c);
    check_zero(1, acc_i, ftw_i, wrap_i, val_i, ph_i, tri_i, sq_i);
    @(negedge clk);
    tick();
    reset_n  = 1'b1;
    dds_freq = 32'h5555_5555;
    for (int k = 0; k < 8; k++) tick();
    chk("post_rst_acc", 0, acc_c, 32'h0);
    chk("post_rst_ftw", 0, ftw_c, 32'h0);
    chk("post_rst_ftw_i", 1, ftw_i, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
